// File: rtl/bb8_ctrl.sv
// bb8_ctrl: fetch/decode/execute sequencer for an 8-instruction accumulator CPU; optional HLT opcode under BB8_HLT_EN.
// Latency: 3 enabled clocks per instruction; STR write and JMP/JZ load take effect on the third edge.
// Backpressure: enable=0 holds state and IR and gates every strobe; phase flags and mem_adr keep showing the held phase.
module bb8_ctrl #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [ADDR_W+2:0] instr,
    input  logic [ADDR_W-1:0] pc_adr,
    input  logic              acc_zero,
    output logic              fetch,
    output logic              decode,
    output logic              execute,
    output logic              pc_enable,
    output logic              pc_load,
    output logic [ADDR_W-1:0] nxt_adr,
    output logic [ADDR_W-1:0] mem_adr,
    output logic              mem_we,
    output logic              acc_load,
    output logic [1:0]        alu_op,
    output logic              halted
);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LD  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_STR = 3'b100;
    localparam logic [2:0] OP_JMP = 3'b101;
    localparam logic [2:0] OP_JZ  = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

`ifdef BB8_HLT_EN
    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DECODE  = 2'd1,
        S_EXECUTE = 2'd2,
        S_HALT    = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DECODE  = 2'd1,
        S_EXECUTE = 2'd2
    } state_t;
`endif

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W+2:0] ir;
    logic [2:0]        op;
    logic [ADDR_W-1:0] operand;
    logic              run;

    assign op      = ir[ADDR_W+2:ADDR_W];
    assign operand = ir[ADDR_W-1:0];
    // Strobes only fire on a cycle that will actually advance; reset aborts the current one.
    assign run     = enable & ~reset;

    // State and instruction register; IR is captured only while leaving FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            ir    <= '0;
        end else if (enable) begin
            state <= state_nxt;
            if (state == S_FETCH) begin
                ir <= instr;
            end
        end
    end

    // Next-state: fixed three-phase ring, with an exit to HALT when HLT is built.
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:   state_nxt = S_DECODE;
            S_DECODE:  state_nxt = S_EXECUTE;
            S_EXECUTE: begin
                state_nxt = S_FETCH;
`ifdef BB8_HLT_EN
                if (op == OP_HLT) begin
                    state_nxt = S_HALT;
                end
`endif
            end
`ifdef BB8_HLT_EN
            S_HALT:    state_nxt = S_HALT;
`endif
            default:   state_nxt = S_FETCH;
        endcase
    end

    // Phase flags, RAM address and per-opcode strobes for the current phase.
    always_comb begin
        fetch     = 1'b0;
        decode    = 1'b0;
        execute   = 1'b0;
        halted    = 1'b0;
        pc_enable = 1'b0;
        pc_load   = 1'b0;
        nxt_adr   = '0;
        mem_adr   = pc_adr;
        mem_we    = 1'b0;
        acc_load  = 1'b0;
        alu_op    = 2'b00;
        case (state)
            S_FETCH: begin
                fetch = 1'b1;
            end
            S_DECODE: begin
                decode    = 1'b1;
                mem_adr   = operand;
                pc_enable = run;
            end
            S_EXECUTE: begin
                execute = 1'b1;
                mem_adr = operand;
                if (run) begin
                    case (op)
                        OP_LD: begin
                            acc_load = 1'b1;
                            alu_op   = 2'b00;
                        end
                        OP_ADD: begin
                            acc_load = 1'b1;
                            alu_op   = 2'b01;
                        end
                        OP_SUB: begin
                            acc_load = 1'b1;
                            alu_op   = 2'b10;
                        end
                        OP_STR: begin
                            mem_we = 1'b1;
                        end
                        OP_JMP: begin
                            pc_load = 1'b1;
                            nxt_adr = operand;
                        end
                        OP_JZ: begin
                            pc_load = acc_zero;
                            nxt_adr = operand;
                        end
                        OP_NOP, OP_HLT: begin
                            pc_load = 1'b0;
                        end
                        default: begin
                            pc_load = 1'b0;
                        end
                    endcase
                end
            end
`ifdef BB8_HLT_EN
            S_HALT: begin
                halted = 1'b1;
            end
`endif
            default: begin
                fetch = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bb8_ctrl.sv
// tb_bb8_ctrl: directed programs run on a small PC/accumulator/RAM environment around bb8_ctrl.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: enable is toggled directly by the stimulus.
module tb_bb8_ctrl;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [AW+2:0] instr;
    logic [AW-1:0] pc_adr;
    logic          acc_zero;
    logic          fetch, decode, execute;
    logic          pc_enable, pc_load, mem_we, acc_load, halted;
    logic [AW-1:0] nxt_adr, mem_adr;
    logic [1:0]    alu_op;

    logic [7:0]    mem  [32];
    logic [7:0]    prog [32];
    logic          load_prog;
    logic [7:0]    acc;
    logic [AW-1:0] pc;
    int            pe_cnt;

    int checks   = 0;
    int failures = 0;

    logic [2:0] phs;
    logic [5:0] strb;

    always #5 clk = ~clk;

    assign instr    = mem[mem_adr];
    assign pc_adr   = pc;
    assign acc_zero = (acc == 8'd0);
    assign phs      = {fetch, decode, execute};
    assign strb     = {pc_enable, pc_load, mem_we, acc_load, alu_op};

    bb8_ctrl #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .instr     (instr),
        .pc_adr    (pc_adr),
        .acc_zero  (acc_zero),
        .fetch     (fetch),
        .decode    (decode),
        .execute   (execute),
        .pc_enable (pc_enable),
        .pc_load   (pc_load),
        .nxt_adr   (nxt_adr),
        .mem_adr   (mem_adr),
        .mem_we    (mem_we),
        .acc_load  (acc_load),
        .alu_op    (alu_op),
        .halted    (halted)
    );

    // Environment: program counter, accumulator and RAM driven by the controller strobes.
    always @(posedge clk) begin
        if (load_prog) begin
            for (int i = 0; i < 32; i++) mem[i] <= prog[i];
        end
        if (reset) begin
            pc     <= '0;
            acc    <= '0;
            pe_cnt <= 0;
        end else begin
            if (pc_load)        pc <= nxt_adr;
            else if (pc_enable) pc <= pc + 1'b1;
            if (mem_we) mem[mem_adr] <= acc;
            if (acc_load) begin
                case (alu_op)
                    2'b00:   acc <= instr;
                    2'b01:   acc <= acc + instr;
                    2'b10:   acc <= acc - instr;
                    default: acc <= acc;
                endcase
            end
            if (pc_enable) pe_cnt <= pe_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_prog();
        for (int i = 0; i < 32; i++) prog[i] = 8'h00;
    endtask

    task automatic prog_a();
        clr_prog();
        prog[0] = 8'h23;  // LD 3
        prog[1] = 8'h44;  // ADD 4
        prog[2] = 8'h85;  // STR 5
        prog[3] = 8'h02;
        prog[4] = 8'h05;
    endtask

    // Hold reset for two edges while the program is copied into RAM, then release with enable=1.
    task automatic start();
        reset     = 1'b1;
        enable    = 1'b0;
        load_prog = 1'b1;
        tick();
        tick();
        load_prog = 1'b0;
        reset     = 1'b0;
        enable    = 1'b1;
        #1;
    endtask

    logic [5:0]    exp_strb [9];
    logic [AW-1:0] exp_adr  [9];
    logic [2:0]    exp_phs;

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        load_prog = 1'b0;
        clr_prog();

        exp_strb = '{6'b000000, 6'b100000, 6'b000100,
                     6'b000000, 6'b100000, 6'b000101,
                     6'b000000, 6'b100000, 6'b001000};
        exp_adr  = '{5'd0, 5'd3, 5'd3, 5'd1, 5'd4, 5'd4, 5'd2, 5'd5, 5'd5};

        // Reset state and the LD/ADD/STR program, cycle by cycle.
        prog_a();
        start();
        check("rst_phase",  32'(phs),     32'b100);
        check("rst_strb",   32'(strb),    32'd0);
        check("rst_nxt",    32'(nxt_adr), 32'd0);
        check("rst_halted", 32'(halted),  32'd0);
        check("rst_memadr", 32'(mem_adr), 32'd0);
        for (int c = 0; c < 9; c++) begin
            exp_phs = 3'b100;
            exp_phs = exp_phs >> (c % 3);
            check($sformatf("a_phase%0d", c), 32'(phs),     32'(exp_phs));
            check($sformatf("a_strb%0d", c),  32'(strb),    32'(exp_strb[c]));
            check($sformatf("a_adr%0d", c),   32'(mem_adr), 32'(exp_adr[c]));
            tick();
        end
        check("a_mem5",  32'(mem[5]), 32'd7);
        check("a_pc",    32'(pc),     32'd3);
        check("a_fetch", 32'(fetch),  32'd1);

        // Stall four cycles in DECODE of ADD: increment must happen exactly once.
        start();
        for (int c = 0; c < 4; c++) tick();
        enable = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            check("st_decode", 32'(decode),    32'd1);
            check("st_pcen",   32'(pc_enable), 32'd0);
            check("st_adr",    32'(mem_adr),   32'd4);
            tick();
        end
        enable = 1'b1;
        #1;
        check("st_pcen_resume", 32'(pc_enable), 32'd1);
        for (int c = 0; c < 5; c++) tick();
        check("st_mem5",  32'(mem[5]), 32'd7);
        check("st_pc",    32'(pc),     32'd3);
        check("st_pecnt", 32'(pe_cnt), 32'd3);

        // LD 6 (=5), JZ 7 not taken, NOP, JMP 0 overriding the increment.
        clr_prog();
        prog[0] = 8'h26;
        prog[1] = 8'hC7;
        prog[2] = 8'h00;
        prog[3] = 8'hA0;
        prog[6] = 8'h05;
        start();
        for (int c = 0; c < 5; c++) tick();
        check("jz_exec",  32'(execute), 32'd1);
        check("jz_load",  32'(pc_load), 32'd0);
        for (int c = 0; c < 6; c++) tick();
        check("jmp_exec", 32'(execute),   32'd1);
        check("jmp_load", 32'(pc_load),   32'd1);
        check("jmp_nxt",  32'(nxt_adr),   32'd0);
        check("jmp_pcen", 32'(pc_enable), 32'd0);
        tick();
        check("jmp_fetch", 32'(fetch),   32'd1);
        check("jmp_pc",    32'(pc),      32'd0);
        check("jmp_adr",   32'(mem_adr), 32'd0);

        // Reset during EXECUTE of STR: no write, back to FETCH.
        prog_a();
        start();
        for (int c = 0; c < 8; c++) tick();
        reset = 1'b1;
        #1;
        check("rx_exec", 32'(execute), 32'd1);
        check("rx_strb", 32'(strb),    32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("rx_phase", 32'(phs),    32'b100);
        check("rx_mem5",  32'(mem[5]), 32'd0);

        // JMP to the top address.
        clr_prog();
        prog[0] = 8'hBF;
        start();
        tick();
        tick();
        check("j31_load", 32'(pc_load), 32'd1);
        check("j31_nxt",  32'(nxt_adr), 32'd31);
        tick();
        check("j31_pc",    32'(pc),      32'd31);
        check("j31_adr",   32'(mem_adr), 32'd31);
        check("j31_fetch", 32'(fetch),   32'd1);

        // Opcode 111: HALT when built, NOP otherwise.
        clr_prog();
        prog[0] = 8'hE0;
        start();
        tick();
        tick();
        check("hlt_exec_strb", 32'(strb), 32'd0);
        tick();
`ifdef BB8_HLT_EN
        check("hlt_halted", 32'(halted), 32'd1);
        check("hlt_phase",  32'(phs),    32'd0);
        for (int c = 0; c < 10; c++) begin
            check("hlt_strb", 32'(strb),   32'd0);
            check("hlt_hold", 32'(halted), 32'd1);
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("hlt_rst_halted", 32'(halted), 32'd0);
        check("hlt_rst_phase",  32'(phs),    32'b100);
`else
        check("nop7_halted", 32'(halted),  32'd0);
        check("nop7_phase",  32'(phs),     32'b100);
        check("nop7_adr",    32'(mem_adr), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bb8_ctrl.md
BB8_CTRL -- requirements
Module: bb8_ctrl

Interface
REQ-001 Parameter ADDR_W, default 5, memory/PC address width; instruction width is 3+ADDR_W (opcode in bits [ADDR_W+2:ADDR_W], operand in [ADDR_W-1:0]).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  run qualifier; low freezes the controller.
REQ-005 instr  input  3+ADDR_W  memory read data (combinational-read RAM, valid in the cycle mem_adr is driven).
REQ-006 pc_adr  input  ADDR_W  current PC value (crnt_adr of pc).
REQ-007 acc_zero  input  1  accumulator equals zero.
REQ-008 fetch, decode, execute  output  1 each  one-hot phase indicators.
REQ-009 pc_enable  output  1  PC increment strobe.
REQ-010 pc_load  output  1  PC load strobe; nxt_adr  output  ADDR_W  PC load value.
REQ-011 mem_adr  output  ADDR_W  RAM address; mem_we  output  1  RAM write strobe.
REQ-012 acc_load  output  1  accumulator load strobe; alu_op  output  2  00 pass, 01 add, 10 sub.
REQ-013 halted  output  1  controller stopped by HLT.

Function
REQ-014 States FETCH -> DECODE -> EXECUTE -> FETCH, plus HALT; one transition per enabled clock.
REQ-015 FETCH: mem_adr=pc_adr; internal IR captures instr at the clock edge.
REQ-016 DECODE: mem_adr=IR operand; pc_enable=1 for exactly this cycle.
REQ-017 EXECUTE: mem_adr=IR operand; strobes by opcode: 000 NOP none; 001 LD acc_load=1, alu_op=00; 010 ADD acc_load=1, alu_op=01; 011 SUB acc_load=1, alu_op=10; 100 STR mem_we=1; 101 JMP pc_load=1, nxt_adr=operand; 110 JZ pc_load=acc_zero, nxt_adr=operand; 111 see REQ-026/027.
REQ-018 Every strobe (pc_enable, pc_load, mem_we, acc_load) is one cycle wide and is 0 in any state or opcode not listed for it; alu_op=00 and nxt_adr=0 when unused.
REQ-019 enable=0: state and IR hold, all strobes forced 0, phase indicators and mem_adr still reflect the held state.
REQ-020 enable deasserted mid-instruction resumes at the same phase with no repeated or lost strobe.
REQ-021 JMP/JZ load in EXECUTE overrides the DECODE increment; target 0 and 2^ADDR_W-1 are legal; PC wrap on increment is owned by pc.
REQ-022 Exactly one of fetch/decode/execute is 1 outside HALT; all three 0 in HALT.
REQ-023 Instruction latency: 3 enabled cycles; STR write and JMP load occur on the third edge.

Reset
REQ-024 reset (sampled at rising edge, priority over enable) forces state FETCH, IR 0, halted 0; after reset fetch=1, decode=0, execute=0, all strobes 0, alu_op 00, nxt_adr 0, mem_adr=pc_adr.
REQ-025 reset in any state, including HALT or EXECUTE, aborts the instruction with no strobe in the reset cycle.

Configuration
REQ-026 With BB8_HLT_EN defined, opcode 111 in EXECUTE moves to HALT: halted=1, all strobes 0, remains until reset.
REQ-027 Without BB8_HLT_EN, opcode 111 behaves as NOP, HALT state is not built, halted tied 0.

Verification
REQ-028 Program mem[0]=LD 3, mem[1]=ADD 4, mem[2]=STR 5, mem[3]=2, mem[4]=5, enable=1 -> after 9 edges mem[5]=7, pc_adr=3.
REQ-029 enable low for 4 cycles during DECODE of ADD -> pc_enable asserted exactly once, final mem[5]=7.
REQ-030 JMP 0 at mem[3] -> pc_load=1 with nxt_adr=0 in EXECUTE, next FETCH at address 0; JZ with acc_zero=0 -> pc_load=0.
REQ-031 reset asserted during EXECUTE of STR -> mem_we=0 that cycle, next cycle fetch=1, mem unchanged.
REQ-032 BB8_HLT_EN defined, mem[0]=111_00000 -> halted=1 after 3 edges, strobes stay 0 for 10 cycles; undefined -> treated as NOP, fetch of address 1 follows.
